// File: rtl/fp_addsub_ctrl.sv
// Control FSM for the floating-point add/subtract datapath: sequences alignment,
// fraction add/sub, normalisation, rounding and a single renormalisation pass.
module fp_addsub_ctrl #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 27,
  parameter int CNT_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [EXP_W-1:0] expDiff,
  input  logic             carry,
  input  logic [FRAC_W-1:0] fracResult,
  input  logic             expOverflow,
  input  logic             expUnderflow,
  output logic [EXP_W-1:0] shiftRightQtt,
  output logic             smallerExpSrc,
  output logic             aluOp,
  output logic             alu,
  output logic             normalization_src,
  output logic             shift,
  output logic             shift_src,
  output logic             round,
  output logic             done,
  output logic             zero,
  output logic             ovf,
  output logic             unf
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALIGN = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_ROUND = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [EXP_W:0]   SHIFT_MAX = (EXP_W+1)'(FRAC_W);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAC_W - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] norm_cnt;
  logic [EXP_W:0]   diff_ext;
  logic [EXP_W:0]   diff_mag;
  logic [EXP_W-1:0] shift_sat;

  // One extra magnitude bit so that -2**(EXP_W-1) negates without wrapping.
  always_comb begin
    diff_ext  = {expDiff[EXP_W-1], expDiff};
    diff_mag  = diff_ext[EXP_W] ? -diff_ext : diff_ext;
    shift_sat = (diff_mag > SHIFT_MAX) ? SHIFT_MAX[EXP_W-1:0] : diff_mag[EXP_W-1:0];
  end

  // NOTE: every register here is updated with non-blocking assignments so all
  // next-state decisions see the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      norm_cnt          <= '0;
      shiftRightQtt     <= '0;
      smallerExpSrc     <= 1'b0;
      aluOp             <= 1'b0;
      alu               <= 1'b0;
      normalization_src <= 1'b1;
      shift             <= 1'b0;
      shift_src         <= 1'b0;
      round             <= 1'b0;
      done              <= 1'b0;
      zero              <= 1'b0;
      ovf               <= 1'b0;
      unf               <= 1'b0;
    end else begin
      alu       <= 1'b0;
      shift     <= 1'b0;
      shift_src <= 1'b0;
      round     <= 1'b0;
      done      <= (state == S_DONE);

      case (state)
        S_IDLE: begin
          if (start) begin
            aluOp <= op;
            zero  <= 1'b0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
            state <= S_ALIGN;
          end
        end

        S_ALIGN: begin
          smallerExpSrc     <= ~expDiff[EXP_W-1];
          shiftRightQtt     <= shift_sat;
          normalization_src <= 1'b1;
          norm_cnt          <= '0;
          state             <= S_ADD;
        end

        S_ADD: begin
          alu   <= 1'b1;
          state <= S_NORM;
        end

        S_NORM: begin
          if (expOverflow) begin
            ovf               <= 1'b1;
            normalization_src <= 1'b1;
            state             <= S_DONE;
          end else if (carry) begin
            shift     <= 1'b1;
            shift_src <= 1'b1;
          end else if (fracResult == '0) begin
            zero              <= 1'b1;
            normalization_src <= 1'b1;
            state             <= S_DONE;
          end else if (!fracResult[FRAC_W-1]) begin
            // Left shifts are bounded so a stuck MSB cannot loop forever.
            if (expUnderflow || norm_cnt == CNT_LAST) begin
              unf               <= 1'b1;
              normalization_src <= 1'b1;
              state             <= S_DONE;
            end else begin
              shift    <= 1'b1;
              norm_cnt <= norm_cnt + 1'b1;
            end
          end else if (normalization_src) begin
            state <= S_ROUND;
          end else begin
            normalization_src <= 1'b1;
            state             <= S_DONE;
          end
        end

        S_ROUND: begin
          round             <= 1'b1;
          normalization_src <= 1'b0;
          state             <= S_NORM;
        end

        S_DONE: begin
          if (!start) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_ctrl.sv
// Directed-vector bench for fp_addsub_ctrl: latency, alignment saturation,
// normalisation exits, mid-operation reset and held-start behaviour.
module tb_fp_addsub_ctrl;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 27;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              op;
  logic [EXP_W-1:0]  expDiff;
  logic              carry;
  logic [FRAC_W-1:0] fracResult;
  logic              expOverflow;
  logic              expUnderflow;
  logic [EXP_W-1:0]  shiftRightQtt;
  logic              smallerExpSrc, aluOp, alu, normalization_src;
  logic              shift, shift_src, round, done, zero, ovf, unf;

  fp_addsub_ctrl #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .op                (op),
    .expDiff           (expDiff),
    .carry             (carry),
    .fracResult        (fracResult),
    .expOverflow       (expOverflow),
    .expUnderflow      (expUnderflow),
    .shiftRightQtt     (shiftRightQtt),
    .smallerExpSrc     (smallerExpSrc),
    .aluOp             (aluOp),
    .alu               (alu),
    .normalization_src (normalization_src),
    .shift             (shift),
    .shift_src         (shift_src),
    .round             (round),
    .done              (done),
    .zero              (zero),
    .ovf               (ovf),
    .unf               (unf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-run stimulus knobs and observations
  int         carry_at, ovf_at;
  logic       hold_start;
  int         lshifts, rshifts, rounds, alus;
  logic [7:0] sq_snap;
  logic       sel_snap, ovf_snap;

  localparam logic [FRAC_W-1:0] FRAC_NORM = 27'h4000000;

  // Edge 0 samples start; n counts edges after that until done is seen.
  task automatic run(input logic op_i, input logic [7:0] ed, input logic [FRAC_W-1:0] frac,
                     input logic uflow, output int n);
    op           = op_i;
    expDiff      = ed;
    fracResult   = frac;
    expUnderflow = uflow;
    carry        = 1'b0;
    expOverflow  = 1'b0;
    start        = 1'b1;
    tick();
    check("flags_clear_on_start", {29'd0, zero, ovf, unf}, 32'd0);
    if (!hold_start) start = 1'b0;
    op = ~op_i;
    n = 0; lshifts = 0; rshifts = 0; rounds = 0; alus = 0;
    sq_snap = '0; sel_snap = 1'b0; ovf_snap = 1'b0;
    while (n < 200 && !done) begin
      tick();
      n++;
      if (n == 1) begin
        sq_snap  = shiftRightQtt;
        sel_snap = smallerExpSrc;
      end
      if (n == 3) ovf_snap = ovf;
      if (shift && shift_src)  rshifts++;
      if (shift && !shift_src) lshifts++;
      if (round) rounds++;
      if (alu)   alus++;
      carry       = (n == carry_at);
      expOverflow = (n == ovf_at);
    end
    carry       = 1'b0;
    expOverflow = 1'b0;
    check("done_within_budget", {31'd0, done}, 32'd1);
  endtask

  function automatic logic [18:0] out_vec();
    return {shiftRightQtt, smallerExpSrc, aluOp, alu, normalization_src,
            shift, shift_src, round, done, zero, ovf, unf};
  endfunction

  localparam logic [18:0] RESET_VEC = 19'b00000000_0_0_0_1_0_0_0_0_0_0_0;

  logic [7:0] align_in  [7] = '{8'd40, 8'd27, 8'd26, 8'd0, 8'h80, 8'hE5, 8'hE6};
  logic [7:0] align_qtt [7] = '{8'd27, 8'd27, 8'd26, 8'd0, 8'd27, 8'd27, 8'd26};
  logic       align_sel [7] = '{1'b1,  1'b1,  1'b1,  1'b1, 1'b0,  1'b0,  1'b0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int done_seen;
    rst = 1'b1; start = 1'b0; op = 1'b0; expDiff = '0; carry = 1'b0;
    fracResult = '0; expOverflow = 1'b0; expUnderflow = 1'b0;
    carry_at = -1; ovf_at = -1; hold_start = 1'b0;

    repeat (2) tick();
    check("reset_outputs", {13'd0, out_vec()}, {13'd0, RESET_VEC});
    rst = 1'b0;
    repeat (2) tick();
    check("idle_no_done", {31'd0, done}, 32'd0);

    // Normalised, no-carry add with expDiff = -3
    run(1'b0, 8'hFD, FRAC_NORM, 1'b0, n);
    check("basic_latency", n, 6);
    check("basic_shift_qtt", {24'd0, sq_snap}, 32'd3);
    check("basic_smaller_src", {31'd0, sel_snap}, 32'd0);
    check("basic_flags", {29'd0, zero, ovf, unf}, 32'd0);
    check("basic_aluop", {31'd0, aluOp}, 32'd0);
    check("basic_round_count", rounds, 1);
    check("basic_alu_count", alus, 1);
    check("basic_shift_count", lshifts + rshifts, 0);
    check("basic_norm_src", {31'd0, normalization_src}, 32'd1);
    tick();
    check("done_is_pulse", {31'd0, done}, 32'd0);

    // Alignment magnitude and saturation corners
    for (int i = 0; i < 7; i++) begin
      run(1'b0, align_in[i], FRAC_NORM, 1'b0, n);
      check($sformatf("align_qtt_%0h", align_in[i]), {24'd0, sq_snap}, {24'd0, align_qtt[i]});
      check($sformatf("align_sel_%0h", align_in[i]), {31'd0, sel_snap}, {31'd0, align_sel[i]});
    end

    // Carry for one NORM cycle: one right shift then round
    carry_at = 2;
    run(1'b0, 8'd1, FRAC_NORM, 1'b0, n);
    carry_at = -1;
    check("carry_latency", n, 7);
    check("carry_right_shifts", rshifts, 1);
    check("carry_left_shifts", lshifts, 0);
    check("carry_rounds", rounds, 1);

    // Subtract with zero result
    run(1'b1, 8'd0, '0, 1'b0, n);
    check("zero_latency", n, 4);
    check("zero_aluop", {31'd0, aluOp}, 32'd1);
    check("zero_flags", {29'd0, zero, ovf, unf}, 32'b100);
    check("zero_no_round", rounds, 0);

    // MSB stuck low: bounded left shifts then underflow
    run(1'b0, 8'd0, 27'h0000001, 1'b0, n);
    check("stuck_left_shifts", lshifts, 26);
    check("stuck_latency", n, 30);
    check("stuck_flags", {29'd0, zero, ovf, unf}, 32'b001);
    check("stuck_norm_src", {31'd0, normalization_src}, 32'd1);

    // Exponent underflow stops normalisation immediately
    run(1'b0, 8'd0, 27'h0000001, 1'b1, n);
    check("uflow_latency", n, 4);
    check("uflow_left_shifts", lshifts, 0);
    check("uflow_flags", {29'd0, zero, ovf, unf}, 32'b001);

    // Overflow wins over a simultaneous carry
    ovf_at = 2; carry_at = 2;
    run(1'b0, 8'd0, FRAC_NORM, 1'b0, n);
    ovf_at = -1; carry_at = -1;
    check("ovf_next_edge", {31'd0, ovf_snap}, 32'd1);
    check("ovf_latency", n, 4);
    check("ovf_no_shift", rshifts, 0);
    check("ovf_flags", {29'd0, zero, ovf, unf}, 32'b010);
    tick();

    // Reset while in ADD
    op = 1'b1; expDiff = 8'd5; fracResult = FRAC_NORM; expUnderflow = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("pre_reset_qtt", {24'd0, shiftRightQtt}, 32'd5);
    rst = 1'b1;
    tick();
    check("mid_reset_outputs", {13'd0, out_vec()}, {13'd0, RESET_VEC});
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || alu || round || shift) done_seen++;
    end
    check("no_partial_result", done_seen, 0);

    // start held high through the operation keeps done asserted
    hold_start = 1'b1;
    run(1'b0, 8'd2, FRAC_NORM, 1'b0, n);
    check("hold_latency", n, 6);
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) done_seen++;
    end
    check("hold_done_stays", done_seen, 3);
    hold_start = 1'b0;
    start = 1'b0;
    repeat (2) tick();
    check("hold_release", {31'd0, done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
